// File: rtl/draw_scheduler.sv
// Draw command scheduler: queues clear-screen and line commands, then sequences
// framebuffer writes either from an internal raster scan or an external line drawer.
module draw_scheduler #(
    parameter int FIFO_DEPTH   = 8,
    parameter int DELAY_CYCLES = 25_000_000,
    parameter int SCR_W        = 640,
    parameter int SCR_H        = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_clear,
    input  logic [10:0] cmd_x0,
    input  logic [10:0] cmd_y0,
    input  logic [10:0] cmd_x1,
    input  logic [10:0] cmd_y1,
    input  logic        cmd_color,
    input  logic        abort,
    output logic        ld_start,
    output logic [10:0] ld_x0,
    output logic [10:0] ld_y0,
    output logic [10:0] ld_x1,
    output logic [10:0] ld_y1,
    input  logic [10:0] ld_x,
    input  logic [10:0] ld_y,
    input  logic        ld_done,
    output logic [10:0] fb_x,
    output logic [10:0] fb_y,
    output logic        fb_color,
    output logic        fb_write,
    output logic        busy,
    output logic [3:0]  fifo_count,
    output logic        drop_err
);

    localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_L  = 5'(FIFO_DEPTH);
    localparam logic [10:0] W_L      = 11'(SCR_W);
    localparam logic [10:0] H_L      = 11'(SCR_H);
    localparam logic [10:0] W_LAST   = 11'(SCR_W - 1);
    localparam logic [10:0] H_LAST   = 11'(SCR_H - 1);
    localparam logic [31:0] DLY_LAST = 32'(DELAY_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DELAY} state_t;

    typedef struct packed {
        logic        clr;
        logic [10:0] x0;
        logic [10:0] y0;
        logic [10:0] x1;
        logic [10:0] y1;
        logic        color;
    } cmd_t;

    cmd_t          fifo_mem [FIFO_DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic          push, pop, load_line, drop, line_ok;

    state_t        state_reg, state_next;
    logic [10:0]   cx_reg, cy_reg;
    logic [31:0]   dly_cnt_reg;
    logic [1:0]    draw_cnt_reg;
    logic          color_reg;
    logic [10:0]   fb_x_reg, fb_y_reg;
    logic          fb_color_reg;

    assign cmd_ready = ({1'b0, fifo_count} < DEPTH_L);
    assign busy      = (state_reg != IDLE) || (fifo_count != 4'd0);
    assign head      = fifo_mem[rd_ptr_reg];
    assign line_ok   = (head.x0 < W_L) && (head.x1 < W_L) &&
                       (head.y0 < H_L) && (head.y1 < H_L);

    // Command storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_clear, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
        end
    end

    always_comb begin
        state_next = state_reg;
        push       = cmd_valid && cmd_ready && !abort;
        pop        = 1'b0;
        load_line  = 1'b0;
        drop       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fifo_count != 4'd0) begin
                    pop = 1'b1;
                    if (head.clr) begin
                        state_next = CLEAR;
                    end else if (line_ok) begin
                        state_next = DRAW;
                        load_line  = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (cx_reg == W_LAST && cy_reg == H_LAST) state_next = IDLE;
            end
            DRAW: begin
                // The drawer's done may still be high from the previous line for
                // the first two cycles, so it only counts from the third cycle.
                if (draw_cnt_reg == 2'd2 && ld_done)
                    state_next = (DELAY_CYCLES == 0) ? IDLE : DELAY;
            end
            DELAY: begin
                if (dly_cnt_reg == DLY_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            pop        = 1'b0;
            load_line  = 1'b0;
            drop       = 1'b0;
        end
    end

    always_comb begin
        fb_write = 1'b0;
        fb_x     = fb_x_reg;
        fb_y     = fb_y_reg;
        fb_color = fb_color_reg;
        case (state_reg)
            CLEAR: begin
                fb_write = 1'b1;
                fb_x     = cx_reg;
                fb_y     = cy_reg;
                fb_color = 1'b0;
            end
            DRAW: begin
                fb_write = 1'b1;
                fb_x     = ld_x;
                fb_y     = ld_y;
                fb_color = color_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_count   <= 4'd0;
            cx_reg       <= 11'd0;
            cy_reg       <= 11'd0;
            dly_cnt_reg  <= 32'd0;
            draw_cnt_reg <= 2'd0;
            drop_err     <= 1'b0;
            ld_start     <= 1'b0;
            ld_x0        <= 11'd0;
            ld_y0        <= 11'd0;
            ld_x1        <= 11'd0;
            ld_y1        <= 11'd0;
            color_reg    <= 1'b0;
            fb_x_reg     <= 11'd0;
            fb_y_reg     <= 11'd0;
            fb_color_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ld_start     <= load_line;
            fb_x_reg     <= fb_x;
            fb_y_reg     <= fb_y;
            fb_color_reg <= fb_color;
            if (drop) drop_err <= 1'b1;
            if (load_line) begin
                ld_x0     <= head.x0;
                ld_y0     <= head.y0;
                ld_x1     <= head.x1;
                ld_y1     <= head.y1;
                color_reg <= head.color;
            end
            if (abort) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                fifo_count <= 4'd0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                if (push && !pop)      fifo_count <= fifo_count + 4'd1;
                else if (pop && !push) fifo_count <= fifo_count - 4'd1;
            end
            // Scan counters rest at zero so every clear starts at (0,0).
            if (abort || state_reg != CLEAR) begin
                cx_reg <= 11'd0;
                cy_reg <= 11'd0;
            end else if (cx_reg == W_LAST) begin
                cx_reg <= 11'd0;
                cy_reg <= (cy_reg == H_LAST) ? 11'd0 : cy_reg + 11'd1;
            end else begin
                cx_reg <= cx_reg + 11'd1;
            end
            if (state_reg != DRAW)        draw_cnt_reg <= 2'd0;
            else if (draw_cnt_reg != 2'd2) draw_cnt_reg <= draw_cnt_reg + 2'd1;
            if (state_reg != DELAY) dly_cnt_reg <= 32'd0;
            else                    dly_cnt_reg <= dly_cnt_reg + 32'd1;
        end
    end

endmodule
